// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit, its decoder and the result mux.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::MD_WIDTH
);
  import muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, dz, hi, lo
  );

endinterface

// File: rtl/muldiv_fixup.sv
// Combinational sign correction of the raw magnitude result before it is written to HI/LO.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic               div_zero,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign neg_res = neg_a ^ neg_b;

  always_comb begin
    prod = neg_res ? (~acc + 1'b1) : acc;
    quo  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    // Remainder follows the dividend's sign, independent of the divisor.
    rem  = neg_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
    if (div_zero) begin
      hi = acc[2*WIDTH-1:WIDTH];
      lo = acc[WIDTH-1:0];
    end else if (is_div) begin
      hi = rem;
      lo = quo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle,
// results held in architectural HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  md
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  muldiv_state_t      state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               div_reg;
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic               dz_pend_reg;
  logic               dz_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               accept;
  logic               start_div;
  logic               start_signed;
  logic               start_dz;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               div_ge;
  logic [WIDTH-1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;

  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // start is only honoured when no operation is in flight.
  assign accept       = md.start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign start_div    = op_is_div(md.op);
  assign start_signed = op_is_signed(md.op);
  assign start_dz     = start_div && (md.b == '0);
  assign abs_a        = (start_signed && md.a[WIDTH-1]) ? (~md.a + 1'b1) : md.a;
  assign abs_b        = (start_signed && md.b[WIDTH-1]) ? (~md.b + 1'b1) : md.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (accept) state_next = start_dz ? ST_FIX : ST_RUN;
      ST_RUN:  if (count_reg == LAST_ITER) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = accept ? (start_dz ? ST_FIX : ST_RUN) : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Multiply: low half holds the multiplier, consumed LSB first while partial sums shift in from the top.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at the bottom.
  assign div_ge    = acc_reg[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_reg};
  assign div_trial = acc_reg[2*WIDTH-2:WIDTH-1] - opnd_reg;
  assign div_next  = div_ge ? {div_trial, acc_reg[WIDTH-2:0], 1'b1}
                            : {acc_reg[2*WIDTH-2:0], 1'b0};

  muldiv_fixup #(.WIDTH(WIDTH)) u_fixup (
    .is_div   (div_reg),
    .div_zero (dz_pend_reg),
    .neg_a    (neg_a_reg),
    .neg_b    (neg_b_reg),
    .acc      (acc_reg),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      div_reg     <= 1'b0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      dz_pend_reg <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (accept) begin
      count_reg   <= '0;
      div_reg     <= start_div;
      neg_a_reg   <= start_signed && md.a[WIDTH-1];
      neg_b_reg   <= start_signed && md.b[WIDTH-1];
      dz_pend_reg <= start_dz;
      dz_reg      <= 1'b0;
      opnd_reg    <= start_div ? abs_b : abs_a;
      if (start_dz)       acc_reg <= {md.a, {WIDTH{1'b1}}};
      else if (start_div) acc_reg <= {{WIDTH{1'b0}}, abs_a};
      else                acc_reg <= {{WIDTH{1'b0}}, abs_b};
    end else if (state_reg == ST_RUN) begin
      count_reg <= count_reg + 1'b1;
      acc_reg   <= div_reg ? div_next : mul_next;
    end else if (state_reg == ST_FIX) begin
      hi_reg <= fix_hi;
      lo_reg <= fix_lo;
      dz_reg <= dz_pend_reg;
    end
  end

  assign md.busy = (state_reg == ST_RUN) || (state_reg == ST_FIX);
  assign md.done = (state_reg == ST_DONE);
  assign md.dz   = dz_reg;
  assign md.hi   = hi_reg;
  assign md.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  muldiv_if #(.WIDTH(32)) md ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  task automatic ref_model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      OP_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFFFFFF;
        end else if (op == OP_DIVU) begin
          lo = a / b; hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = 32'h80000000; hi = 32'd0;
        end else begin
          sp = sa / sb; lo = sp[31:0];
          sp = sa % sb; hi = sp[31:0];
        end
      end
    endcase
  endtask

  // Launches one op and follows it to its done cycle (returns during that cycle).
  // now=1 drives start in the current cycle (e.g. during a done pulse).
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input bit now, input string tag);
    logic [31:0] exp_hi, exp_lo, old_hi, old_lo;
    logic exp_dz;
    int cycles, busy_cnt, exp_lat;
    bit stable;
    ref_model(op, a, b, exp_hi, exp_lo, exp_dz);
    exp_lat = exp_dz ? 2 : 34;
    if (!now) @(negedge clk);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b;
    old_hi = md.hi; old_lo = md.lo;
    @(negedge clk);
    md.start = 1'b0;
    cycles = 1; busy_cnt = 0; stable = 1'b1;
    check({tag, "_dz_clear"}, {63'd0, md.dz}, 64'd0);
    while (!md.done && cycles < 100) begin
      if (md.busy) busy_cnt++;
      if (md.hi !== old_hi || md.lo !== old_lo) stable = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_hilo_stable"}, {63'd0, stable}, 64'd1);
    check({tag, "_hi"}, {32'd0, md.hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, md.lo}, {32'd0, exp_lo});
    check({tag, "_dz"}, {63'd0, md.dz}, {63'd0, exp_dz});
    $display("op=%s a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", op.name(), a, b, md.hi, md.lo, md.dz, cycles);
  endtask

  initial begin
    int cyc, done_cnt, first_done;
    logic [31:0] r_a, r_b, e_hi, e_lo;
    logic [1:0] r_op;
    logic e_dz;

    md.start = 1'b0; md.op = OP_MULTU; md.a = '0; md.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, md.busy}, 64'd0);
    check("rst_done", {63'd0, md.done}, 64'd0);
    check("rst_dz",   {63'd0, md.dz}, 64'd0);
    check("rst_hilo", {md.hi, md.lo}, 64'd0);
    rst_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    @(negedge clk);
    check("done_pulse_width", {63'd0, md.done}, 64'd0);
    run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b0, "mult_neg");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, "div_neg");
    run_op(OP_DIVU,  32'd100,      32'd7,        1'b0, "divu_100_7");
    run_op(OP_DIVU,  32'h00000064, 32'd0,        1'b0, "divu_zero");
    run_op(OP_MULTU, 32'd3,        32'd5,        1'b0, "multu_after_dz");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    run_op(OP_DIV,   32'hFFFFFF00, 32'd0,        1'b0, "div_zero_neg");

    // Back-to-back: second start issued while done is high.
    run_op(OP_MULT,  32'h12345678, 32'h87654321, 1'b0, "b2b_first");
    run_op(OP_DIV,   32'h87654321, 32'h00001234, 1'b1, "b2b_second");

    // Starts during busy must be ignored.
    ref_model(OP_MULTU, 32'd12345, 32'd6789, e_hi, e_lo, e_dz);
    @(negedge clk);
    md.start = 1'b1; md.op = OP_MULTU; md.a = 32'd12345; md.b = 32'd6789;
    @(negedge clk);
    md.start = 1'b0;
    cyc = 1; done_cnt = 0; first_done = 0;
    while (cyc <= 70) begin
      if (md.done) begin
        done_cnt++;
        if (first_done == 0) first_done = cyc;
      end
      md.start = (cyc == 5 || cyc == 20);
      md.op = OP_DIVU; md.a = $urandom; md.b = 32'd3;
      @(negedge clk);
      cyc++;
    end
    md.start = 1'b0;
    check("ignore_done_count", 64'(done_cnt), 64'd1);
    check("ignore_latency", 64'(first_done), 64'd34);
    check("ignore_hilo", {md.hi, md.lo}, {e_hi, e_lo});
    $display("op=MULTU with ignored starts -> hi=%h lo=%h done_count=%0d", md.hi, md.lo, done_cnt);

    // Reset mid-divide.
    @(negedge clk);
    md.start = 1'b1; md.op = OP_DIV; md.a = 32'h7FFF1234; md.b = 32'd77;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, md.busy}, 64'd0);
    check("midrst_done", {63'd0, md.done}, 64'd0);
    check("midrst_hilo", {md.hi, md.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done || md.busy) done_cnt++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    $display("op=DIV aborted by reset -> hi=%h lo=%h", md.hi, md.lo);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_a = 32'($urandom_range(0, 255));
        3: r_b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(muldiv_op_t'(r_op), r_a, r_b, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
